// File: rtl/axi_arb_pkg.sv
// Shared definitions for the duplex AXI-to-DDR command arbiter: state encoding,
// last-grant selectors and the outstanding-counter width helper.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_WR = 2'd1,
    GNT_RD = 2'd2
  } arb_state_t;

  localparam logic GNT_WR_SEL = 1'b0;
  localparam logic GNT_RD_SEL = 1'b1;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/axi_arb_outstanding_cnt.sv
// Saturating up/down counter for outstanding transactions; inc+dec together is net zero
// and a decrement at zero is dropped.
module axi_arb_outstanding_cnt
  import axi_arb_pkg::*;
#(
  parameter int MAX = 4,
  localparam int W = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty
);

  assign full  = (count == W'(MAX));
  assign empty = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + 1'b1;
    end else if (dec && !inc && !empty) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/axi_duplex_arbiter_rr.sv
// Full-duplex AXI slave onto a half-duplex DDR command port, with per-direction limits and W gating.
// Define AXI_ARB_STRICT_WR_PRIO_EN to replace round-robin with fixed write priority.
module axi_duplex_arbiter_rr
  import axi_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int MAX_WR_OUT = 4,
  parameter int MAX_RD_OUT = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ID_WIDTH-1:0]               s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]             s_axi_awaddr,
  input  logic [7:0]                        s_axi_awlen,
  input  logic [2:0]                        s_axi_awsize,
  input  logic [1:0]                        s_axi_awburst,
  input  logic                              s_axi_awlock,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [DATA_WIDTH-1:0]             s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]           s_axi_wstrb,
  input  logic                              s_axi_wlast,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  output logic [ID_WIDTH-1:0]               s_axi_bid,
  output logic [1:0]                        s_axi_bresp,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic [ID_WIDTH-1:0]               s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]             s_axi_araddr,
  input  logic [7:0]                        s_axi_arlen,
  input  logic [2:0]                        s_axi_arsize,
  input  logic [1:0]                        s_axi_arburst,
  input  logic                              s_axi_arlock,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  output logic [ID_WIDTH-1:0]               s_axi_rid,
  output logic [DATA_WIDTH-1:0]             s_axi_rdata,
  output logic [1:0]                        s_axi_rresp,
  output logic                              s_axi_rlast,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic [ADDR_WIDTH-1:0]             io_ddr_arw_payload_addr,
  output logic [ID_WIDTH-1:0]               io_ddr_arw_payload_id,
  output logic [7:0]                        io_ddr_arw_payload_len,
  output logic [2:0]                        io_ddr_arw_payload_size,
  output logic [1:0]                        io_ddr_arw_payload_burst,
  output logic [1:0]                        io_ddr_arw_payload_lock,
  output logic                              io_ddr_arw_payload_write,
  output logic                              io_ddr_arw_valid,
  input  logic                              io_ddr_arw_ready,
  output logic [ID_WIDTH-1:0]               io_ddr_w_payload_id,
  output logic [DATA_WIDTH-1:0]             io_ddr_w_payload_data,
  output logic [DATA_WIDTH/8-1:0]           io_ddr_w_payload_strb,
  output logic                              io_ddr_w_payload_last,
  output logic                              io_ddr_w_valid,
  input  logic                              io_ddr_w_ready,
  input  logic [ID_WIDTH-1:0]               io_ddr_b_payload_id,
  input  logic                              io_ddr_b_valid,
  output logic                              io_ddr_b_ready,
  input  logic [DATA_WIDTH-1:0]             io_ddr_r_payload_data,
  input  logic [ID_WIDTH-1:0]               io_ddr_r_payload_id,
  input  logic [1:0]                        io_ddr_r_payload_resp,
  input  logic                              io_ddr_r_payload_last,
  input  logic                              io_ddr_r_valid,
  output logic                              io_ddr_r_ready,
  output logic [$clog2(MAX_WR_OUT+1)-1:0]   wr_outstanding,
  output logic [$clog2(MAX_RD_OUT+1)-1:0]   rd_outstanding,
  output logic                              arb_idle
);

  localparam int PW = (MAX_WR_OUT > 1) ? $clog2(MAX_WR_OUT) : 1;

  arb_state_t state;
  logic gnt_wr, gnt_rd, wr_ok, rd_ok;
  logic aw_hs, ar_hs, w_hs, w_last_hs, b_hs, r_last_hs;
  logic wr_full, wr_empty, rd_full, rd_empty, w_pend_empty;
  logic unused_w_pend_full;
  logic [cnt_width(MAX_WR_OUT)-1:0] unused_w_pend_cnt;
  logic [ID_WIDTH-1:0] id_fifo [MAX_WR_OUT];
  logic [PW-1:0] push_ptr, pop_ptr;

  assign gnt_wr = (state == GNT_WR);
  assign gnt_rd = (state == GNT_RD);
  assign wr_ok  = s_axi_awvalid && !wr_full;
  assign rd_ok  = s_axi_arvalid && !rd_full;

  assign aw_hs     = gnt_wr && s_axi_awvalid && io_ddr_arw_ready;
  assign ar_hs     = gnt_rd && s_axi_arvalid && io_ddr_arw_ready;
  assign w_hs      = s_axi_wvalid && io_ddr_w_ready && !w_pend_empty;
  assign w_last_hs = w_hs && s_axi_wlast;
  assign b_hs      = io_ddr_b_valid && s_axi_bready;
  assign r_last_hs = io_ddr_r_valid && s_axi_rready && io_ddr_r_payload_last;

`ifdef AXI_ARB_STRICT_WR_PRIO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (wr_ok)      state <= GNT_WR;
          else if (rd_ok) state <= GNT_RD;
        end
        GNT_WR:  if (aw_hs) state <= IDLE;
        GNT_RD:  if (ar_hs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic last_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= GNT_RD_SEL;
    end else begin
      case (state)
        IDLE: begin
          // On a tie the side that did not win last time gets the grant.
          if (wr_ok && (!rd_ok || last_gnt == GNT_RD_SEL)) begin
            state    <= GNT_WR;
            last_gnt <= GNT_WR_SEL;
          end else if (rd_ok) begin
            state    <= GNT_RD;
            last_gnt <= GNT_RD_SEL;
          end
        end
        GNT_WR:  if (aw_hs) state <= IDLE;
        GNT_RD:  if (ar_hs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`endif

  assign io_ddr_arw_valid = (gnt_wr && s_axi_awvalid) || (gnt_rd && s_axi_arvalid);
  assign s_axi_awready    = gnt_wr && io_ddr_arw_ready;
  assign s_axi_arready    = gnt_rd && io_ddr_arw_ready;

  always_comb begin
    io_ddr_arw_payload_addr  = '0;
    io_ddr_arw_payload_id    = '0;
    io_ddr_arw_payload_len   = '0;
    io_ddr_arw_payload_size  = '0;
    io_ddr_arw_payload_burst = '0;
    io_ddr_arw_payload_lock  = '0;
    io_ddr_arw_payload_write = 1'b0;
    if (gnt_wr) begin
      io_ddr_arw_payload_addr  = s_axi_awaddr;
      io_ddr_arw_payload_id    = s_axi_awid;
      io_ddr_arw_payload_len   = s_axi_awlen;
      io_ddr_arw_payload_size  = s_axi_awsize;
      io_ddr_arw_payload_burst = s_axi_awburst;
      io_ddr_arw_payload_lock  = {1'b0, s_axi_awlock};
      io_ddr_arw_payload_write = 1'b1;
    end else if (gnt_rd) begin
      io_ddr_arw_payload_addr  = s_axi_araddr;
      io_ddr_arw_payload_id    = s_axi_arid;
      io_ddr_arw_payload_len   = s_axi_arlen;
      io_ddr_arw_payload_size  = s_axi_arsize;
      io_ddr_arw_payload_burst = s_axi_arburst;
      io_ddr_arw_payload_lock  = {1'b0, s_axi_arlock};
    end
  end

  axi_arb_outstanding_cnt #(.MAX(MAX_WR_OUT)) u_wr_out (
    .clk(clk), .rst(rst), .inc(aw_hs), .dec(b_hs),
    .count(wr_outstanding), .full(wr_full), .empty(wr_empty)
  );

  axi_arb_outstanding_cnt #(.MAX(MAX_WR_OUT)) u_w_pend (
    .clk(clk), .rst(rst), .inc(aw_hs), .dec(w_last_hs),
    .count(unused_w_pend_cnt), .full(unused_w_pend_full), .empty(w_pend_empty)
  );

  axi_arb_outstanding_cnt #(.MAX(MAX_RD_OUT)) u_rd_out (
    .clk(clk), .rst(rst), .inc(ar_hs), .dec(r_last_hs),
    .count(rd_outstanding), .full(rd_full), .empty(rd_empty)
  );

  // W carries no ID on AXI, so accepted AW IDs are queued to tag each forwarded burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_ptr <= '0;
      pop_ptr  <= '0;
    end else begin
      if (aw_hs)     push_ptr <= (push_ptr == PW'(MAX_WR_OUT-1)) ? '0 : push_ptr + 1'b1;
      if (w_last_hs) pop_ptr  <= (pop_ptr  == PW'(MAX_WR_OUT-1)) ? '0 : pop_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) id_fifo[push_ptr] <= s_axi_awid;
  end

  assign io_ddr_w_valid        = s_axi_wvalid && !w_pend_empty;
  assign s_axi_wready          = io_ddr_w_ready && !w_pend_empty;
  assign io_ddr_w_payload_id   = id_fifo[pop_ptr];
  assign io_ddr_w_payload_data = s_axi_wdata;
  assign io_ddr_w_payload_strb = s_axi_wstrb;
  assign io_ddr_w_payload_last = s_axi_wlast;

  assign s_axi_bid      = io_ddr_b_payload_id;
  assign s_axi_bresp    = 2'b00;
  assign s_axi_bvalid   = io_ddr_b_valid;
  assign io_ddr_b_ready = s_axi_bready;

  assign s_axi_rid      = io_ddr_r_payload_id;
  assign s_axi_rdata    = io_ddr_r_payload_data;
  assign s_axi_rresp    = io_ddr_r_payload_resp;
  assign s_axi_rlast    = io_ddr_r_payload_last;
  assign s_axi_rvalid   = io_ddr_r_valid;
  assign io_ddr_r_ready = s_axi_rready;

  assign arb_idle = (state == IDLE) && wr_empty && rd_empty;

endmodule

// File: tb/tb_axi_duplex_arbiter_rr.sv
// Directed and randomized bench for axi_duplex_arbiter_rr against a transaction-level model.
`timescale 1ns/1ps
module tb_axi_duplex_arbiter_rr;
  localparam int DW = 32, AW = 32, IW = 8, MWR = 4, MRD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [IW-1:0] s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0] s_axi_awlen, s_axi_arlen;
  logic [2:0] s_axi_awsize, s_axi_arsize;
  logic [1:0] s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic s_axi_awlock, s_axi_awvalid, s_axi_awready, s_axi_arlock, s_axi_arvalid, s_axi_arready;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic s_axi_wlast, s_axi_wvalid, s_axi_wready, s_axi_bvalid, s_axi_bready;
  logic s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [AW-1:0] io_ddr_arw_payload_addr;
  logic [IW-1:0] io_ddr_arw_payload_id, io_ddr_w_payload_id, io_ddr_b_payload_id, io_ddr_r_payload_id;
  logic [7:0] io_ddr_arw_payload_len;
  logic [2:0] io_ddr_arw_payload_size;
  logic [1:0] io_ddr_arw_payload_burst, io_ddr_arw_payload_lock, io_ddr_r_payload_resp;
  logic io_ddr_arw_payload_write, io_ddr_arw_valid, io_ddr_arw_ready;
  logic [DW-1:0] io_ddr_w_payload_data, io_ddr_r_payload_data;
  logic [DW/8-1:0] io_ddr_w_payload_strb;
  logic io_ddr_w_payload_last, io_ddr_w_valid, io_ddr_w_ready;
  logic io_ddr_b_valid, io_ddr_b_ready;
  logic io_ddr_r_payload_last, io_ddr_r_valid, io_ddr_r_ready;
  logic [$clog2(MWR+1)-1:0] wr_outstanding;
  logic [$clog2(MRD+1)-1:0] rd_outstanding;
  logic arb_idle;

  axi_duplex_arbiter_rr #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_WR_OUT(MWR), .MAX_RD_OUT(MRD)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .io_ddr_arw_payload_addr(io_ddr_arw_payload_addr), .io_ddr_arw_payload_id(io_ddr_arw_payload_id),
    .io_ddr_arw_payload_len(io_ddr_arw_payload_len), .io_ddr_arw_payload_size(io_ddr_arw_payload_size),
    .io_ddr_arw_payload_burst(io_ddr_arw_payload_burst), .io_ddr_arw_payload_lock(io_ddr_arw_payload_lock),
    .io_ddr_arw_payload_write(io_ddr_arw_payload_write), .io_ddr_arw_valid(io_ddr_arw_valid),
    .io_ddr_arw_ready(io_ddr_arw_ready),
    .io_ddr_w_payload_id(io_ddr_w_payload_id), .io_ddr_w_payload_data(io_ddr_w_payload_data),
    .io_ddr_w_payload_strb(io_ddr_w_payload_strb), .io_ddr_w_payload_last(io_ddr_w_payload_last),
    .io_ddr_w_valid(io_ddr_w_valid), .io_ddr_w_ready(io_ddr_w_ready),
    .io_ddr_b_payload_id(io_ddr_b_payload_id), .io_ddr_b_valid(io_ddr_b_valid), .io_ddr_b_ready(io_ddr_b_ready),
    .io_ddr_r_payload_data(io_ddr_r_payload_data), .io_ddr_r_payload_id(io_ddr_r_payload_id),
    .io_ddr_r_payload_resp(io_ddr_r_payload_resp), .io_ddr_r_payload_last(io_ddr_r_payload_last),
    .io_ddr_r_valid(io_ddr_r_valid), .io_ddr_r_ready(io_ddr_r_ready),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding), .arb_idle(arb_idle)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
    s_axi_awburst = '0; s_axi_awlock = 1'b0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arlock = 1'b0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    io_ddr_arw_ready = 1'b0; io_ddr_w_ready = 1'b0;
    io_ddr_b_payload_id = '0; io_ddr_b_valid = 1'b0;
    io_ddr_r_payload_data = '0; io_ddr_r_payload_id = '0; io_ddr_r_payload_resp = '0;
    io_ddr_r_payload_last = 1'b0; io_ddr_r_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // transaction-level model state for the random phase
  int m_wr, m_rd, m_wp, m_bdue;
  logic [IW-1:0] aw_q[$];

  initial begin
    logic seq[4];
    logic exp_seq[4];
    logic [DW-1:0] wd[3];
    int n, passed;
    logic aw_done, found, hs_aw, hs_ar, hs_w, hs_wl, hs_b, hs_r, hs_rl;
    logic [IW-1:0] aw_id_s;

    idle_inputs();
    @(negedge clk);
    chk("rst_arw_valid", io_ddr_arw_valid, 0);
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_wr_out", wr_outstanding, 0);
    chk("rst_rd_out", rd_outstanding, 0);
    chk("rst_arb_idle", arb_idle, 1);

    // both AW and AR held valid: grant order
    do_reset();
    s_axi_awvalid = 1; s_axi_awid = 8'h11; s_axi_awaddr = 32'h1000_0000; s_axi_awlock = 1;
    s_axi_arvalid = 1; s_axi_arid = 8'h22; s_axi_araddr = 32'h2000_0000; io_ddr_arw_ready = 1;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      @(negedge clk);
      if (io_ddr_arw_valid && io_ddr_arw_ready) begin
        seq[n] = io_ddr_arw_payload_write;
        n++;
        if (io_ddr_arw_payload_write) begin
          chk("arb_aw_addr", io_ddr_arw_payload_addr, 32'h1000_0000);
          chk("arb_aw_lock", io_ddr_arw_payload_lock, 2'b01);
          chk("arb_awready", s_axi_awready, 1);
          chk("arb_arready_low", s_axi_arready, 0);
        end else begin
          chk("arb_ar_addr", io_ddr_arw_payload_addr, 32'h2000_0000);
          chk("arb_arready", s_axi_arready, 1);
        end
      end
      next_cycle();
    end
    chk("arb_cmd_count", n, 4);
`ifdef AXI_ARB_STRICT_WR_PRIO_EN
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
    for (int i = 0; i < 4; i++) chk($sformatf("arb_seq%0d", i), seq[i], exp_seq[i]);
    s_axi_awvalid = 0; s_axi_arvalid = 0;
    @(negedge clk);
`ifdef AXI_ARB_STRICT_WR_PRIO_EN
    chk("arb_wr_out", wr_outstanding, 4);
    chk("arb_rd_out", rd_outstanding, 0);
`else
    chk("arb_wr_out", wr_outstanding, 2);
    chk("arb_rd_out", rd_outstanding, 2);
`endif

    // W beats presented before their AW
    do_reset();
    wd[0] = 32'hA000_0001; wd[1] = 32'hA000_0002; wd[2] = 32'hA000_0003;
    s_axi_wvalid = 1; s_axi_wdata = wd[0]; s_axi_wlast = 0; io_ddr_w_ready = 1;
    repeat (3) begin
      @(negedge clk);
      chk("wgate_hold_valid", io_ddr_w_valid, 0);
      chk("wgate_hold_ready", s_axi_wready, 0);
      next_cycle();
    end
    s_axi_awvalid = 1; s_axi_awid = 8'h33; io_ddr_arw_ready = 1;
    aw_done = 0; passed = 0;
    for (int c = 0; c < 30 && passed < 3; c++) begin
      @(negedge clk);
      if (!aw_done) chk("wgate_pre_aw", io_ddr_w_valid, 0);
      hs_w = s_axi_wvalid && s_axi_wready;
      hs_aw = io_ddr_arw_valid && io_ddr_arw_ready;
      if (hs_w) begin
        chk("wgate_data", io_ddr_w_payload_data, wd[passed]);
        chk("wgate_id", io_ddr_w_payload_id, 8'h33);
        chk("wgate_last", io_ddr_w_payload_last, passed == 2);
      end
      next_cycle();
      if (hs_aw) begin aw_done = 1; s_axi_awvalid = 0; end
      if (hs_w) begin
        passed++;
        if (passed < 3) begin s_axi_wdata = wd[passed]; s_axi_wlast = (passed == 2); end
      end
    end
    chk("wgate_beats", passed, 3);
    s_axi_wdata = 32'hBBBB_0000; s_axi_wlast = 0;
    @(negedge clk);
    chk("wgate_pend_clear", io_ddr_w_valid, 0);
    chk("wgate_wr_out", wr_outstanding, 1);

    // read outstanding limit, then R passthrough releases the third AR
    do_reset();
    s_axi_arvalid = 1; s_axi_arid = 8'h44; io_ddr_arw_ready = 1; s_axi_rready = 1;
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clk);
      if (io_ddr_arw_valid && io_ddr_arw_ready) n++;
      next_cycle();
    end
    chk("rdlim_issued", n, 2);
    repeat (4) begin
      @(negedge clk);
      chk("rdlim_arready", s_axi_arready, 0);
      chk("rdlim_arw_valid", io_ddr_arw_valid, 0);
      chk("rdlim_rd_out", rd_outstanding, 2);
      next_cycle();
    end
    io_ddr_r_valid = 1; io_ddr_r_payload_id = 8'h5A; io_ddr_r_payload_resp = 2'd2;
    io_ddr_r_payload_last = 1; io_ddr_r_payload_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("r_pass_id", s_axi_rid, 8'h5A);
    chk("r_pass_resp", s_axi_rresp, 2'd2);
    chk("r_pass_valid", s_axi_rvalid, 1);
    chk("r_pass_last", s_axi_rlast, 1);
    chk("r_pass_data", s_axi_rdata, 32'hDEAD_BEEF);
    next_cycle();
    io_ddr_r_valid = 0;
    found = 0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk);
      found = io_ddr_arw_valid && io_ddr_arw_ready && !io_ddr_arw_payload_write;
      next_cycle();
    end
    chk("rdlim_third_granted", found, 1);
    @(negedge clk);
    chk("rdlim_rd_out_after", rd_outstanding, 2);

    // B handshake coincident with an AW handshake at wr_out=1
    do_reset();
    s_axi_awvalid = 1; s_axi_awid = 8'h55; io_ddr_arw_ready = 1; s_axi_bready = 1;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      found = io_ddr_arw_valid && io_ddr_arw_ready;
      next_cycle();
    end
    chk("bcoin_first_aw", found, 1);
    io_ddr_arw_ready = 0; s_axi_awid = 8'h56;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      found = io_ddr_arw_valid;
      if (!found) next_cycle();
    end
    chk("bcoin_grant", found, 1);
    chk("bcoin_wr_out_pre", wr_outstanding, 1);
    next_cycle();
    io_ddr_arw_ready = 1; io_ddr_b_valid = 1; io_ddr_b_payload_id = 8'h55;
    @(negedge clk);
    chk("bcoin_aw_hs", io_ddr_arw_valid && io_ddr_arw_ready, 1);
    chk("bcoin_bvalid", s_axi_bvalid, 1);
    chk("bcoin_bid", s_axi_bid, 8'h55);
    chk("bcoin_bresp", s_axi_bresp, 2'b00);
    chk("bcoin_bready", io_ddr_b_ready, 1);
    next_cycle();
    s_axi_awvalid = 0; io_ddr_b_valid = 0;
    @(negedge clk);
    chk("bcoin_wr_out", wr_outstanding, 1);

    // reset asserted while a write grant is stalled
    do_reset();
    s_axi_arvalid = 1; io_ddr_arw_ready = 1;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      found = io_ddr_arw_valid && io_ddr_arw_ready;
      next_cycle();
    end
    s_axi_arvalid = 0; io_ddr_arw_ready = 0; s_axi_awvalid = 1;
    s_axi_wvalid = 1; io_ddr_w_ready = 1;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      found = io_ddr_arw_valid;
      if (!found) next_cycle();
    end
    chk("rstmid_grant", found, 1);
    chk("rstmid_rd_out_pre", rd_outstanding, 1);
    next_cycle();
    rst = 1;
    @(negedge clk);
    chk("rstmid_arw_valid", io_ddr_arw_valid, 0);
    chk("rstmid_awready", s_axi_awready, 0);
    chk("rstmid_arready", s_axi_arready, 0);
    chk("rstmid_w_valid", io_ddr_w_valid, 0);
    chk("rstmid_wready", s_axi_wready, 0);
    chk("rstmid_wr_out", wr_outstanding, 0);
    chk("rstmid_rd_out", rd_outstanding, 0);
    chk("rstmid_arb_idle", arb_idle, 1);

    // randomized traffic against the transaction model
    do_reset();
    m_wr = 0; m_rd = 0; m_wp = 0; m_bdue = 0;
    aw_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      io_ddr_arw_ready = ($urandom_range(0, 3) != 0);
      io_ddr_w_ready   = $urandom_range(0, 1) == 1;
      s_axi_bready     = $urandom_range(0, 2) != 0;
      s_axi_rready     = $urandom_range(0, 2) != 0;
      if (!s_axi_awvalid && $urandom_range(0, 3) == 0) begin
        s_axi_awvalid = 1; s_axi_awid = IW'($urandom); s_axi_awaddr = $urandom;
        s_axi_awlen = 8'($urandom); s_axi_awlock = 1'($urandom);
      end
      if (!s_axi_arvalid && $urandom_range(0, 3) == 0) begin
        s_axi_arvalid = 1; s_axi_arid = IW'($urandom); s_axi_araddr = $urandom;
        s_axi_arlen = 8'($urandom); s_axi_arlock = 1'($urandom);
      end
      if (!s_axi_wvalid && $urandom_range(0, 1) == 0) begin
        s_axi_wvalid = 1; s_axi_wdata = $urandom; s_axi_wstrb = 4'($urandom);
        s_axi_wlast = ($urandom_range(0, 2) == 0);
      end
      if (!io_ddr_b_valid && m_bdue > 0 && $urandom_range(0, 1) == 0) begin
        io_ddr_b_valid = 1; io_ddr_b_payload_id = IW'($urandom);
      end
      if (!io_ddr_r_valid && m_rd > 0 && $urandom_range(0, 1) == 0) begin
        io_ddr_r_valid = 1; io_ddr_r_payload_id = IW'($urandom); io_ddr_r_payload_data = $urandom;
        io_ddr_r_payload_resp = 2'($urandom); io_ddr_r_payload_last = ($urandom_range(0, 2) == 0);
      end

      @(negedge clk);
      chk("rnd_wr_out", wr_outstanding, m_wr);
      chk("rnd_rd_out", rd_outstanding, m_rd);
      chk("rnd_w_valid", io_ddr_w_valid, s_axi_wvalid && m_wp != 0);
      chk("rnd_w_ready", s_axi_wready, io_ddr_w_ready && m_wp != 0);
      if (io_ddr_w_valid && aw_q.size() > 0) begin
        chk("rnd_w_id", io_ddr_w_payload_id, aw_q[0]);
        chk("rnd_w_data", io_ddr_w_payload_data, s_axi_wdata);
      end
      if (io_ddr_arw_valid && io_ddr_arw_payload_write) begin
        chk("rnd_aw_addr", io_ddr_arw_payload_addr, s_axi_awaddr);
        chk("rnd_aw_id", io_ddr_arw_payload_id, s_axi_awid);
        chk("rnd_aw_limit", m_wr < MWR, 1);
        chk("rnd_awready", s_axi_awready, io_ddr_arw_ready);
      end else if (io_ddr_arw_valid) begin
        chk("rnd_ar_addr", io_ddr_arw_payload_addr, s_axi_araddr);
        chk("rnd_ar_len", io_ddr_arw_payload_len, s_axi_arlen);
        chk("rnd_ar_limit", m_rd < MRD, 1);
        chk("rnd_arready", s_axi_arready, io_ddr_arw_ready);
      end else begin
        chk("rnd_idle_addr", io_ddr_arw_payload_addr, 0);
        chk("rnd_idle_awready", s_axi_awready, 0);
        chk("rnd_idle_arready", s_axi_arready, 0);
      end
      chk("rnd_rvalid", s_axi_rvalid, io_ddr_r_valid);
      chk("rnd_rid", s_axi_rid, io_ddr_r_payload_id);
      chk("rnd_rresp", s_axi_rresp, io_ddr_r_payload_resp);
      chk("rnd_r_ready", io_ddr_r_ready, s_axi_rready);
      chk("rnd_bvalid", s_axi_bvalid, io_ddr_b_valid);
      chk("rnd_bid", s_axi_bid, io_ddr_b_payload_id);
      chk("rnd_bresp", s_axi_bresp, 2'b00);
      if (arb_idle) chk("rnd_idle_counts", m_wr + m_rd, 0);

      hs_aw = io_ddr_arw_valid && io_ddr_arw_ready && io_ddr_arw_payload_write;
      hs_ar = io_ddr_arw_valid && io_ddr_arw_ready && !io_ddr_arw_payload_write;
      hs_w  = s_axi_wvalid && s_axi_wready;
      hs_wl = hs_w && s_axi_wlast;
      hs_b  = io_ddr_b_valid && s_axi_bready;
      hs_r  = io_ddr_r_valid && s_axi_rready;
      hs_rl = hs_r && io_ddr_r_payload_last;
      aw_id_s = s_axi_awid;

      next_cycle();
      if (hs_aw) begin aw_q.push_back(aw_id_s); m_wr++; m_wp++; s_axi_awvalid = 0; end
      if (hs_ar) begin m_rd++; s_axi_arvalid = 0; end
      if (hs_w) begin
        s_axi_wvalid = 0;
        if (hs_wl) begin void'(aw_q.pop_front()); m_wp--; m_bdue++; end
      end
      if (hs_b) begin m_wr--; m_bdue--; io_ddr_b_valid = 0; end
      if (hs_r) begin
        io_ddr_r_valid = 0;
        if (hs_rl) m_rd--;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
